// File: rtl/reg_pkg.sv
// Shared definitions for the 64-bit datapath register blocks.
//   REG_W            : datapath register width
//   readout_state_t  : state encoding of the register readout streamer
package reg_pkg;

    localparam int REG_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } readout_state_t;

endpackage

// File: rtl/reg_readout.sv
// Register readout streamer: snapshots reg_in on req and streams it out as
// BEAT_W-wide beats over a valid/ready interface.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req        start a readback (only honoured in IDLE)
//   reg_in     live register value, captured on an accepted req
//   busy       readback in progress
//   out_valid  beat present on out_data
//   out_ready  consumer accepts the beat this cycle
//   out_data   current beat
//   out_last   final beat of the readback
//   done       single-cycle pulse after the final beat is accepted
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; outputs quiet
// SEND  | presenting snapshot beats until the last one is accepted
module reg_readout
    import reg_pkg::*;
#(
    parameter int DATA_W    = REG_W,
    parameter int BEAT_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [DATA_W-1:0] reg_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int NBEATS = DATA_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    generate
        if ((DATA_W % BEAT_W) != 0 || DATA_W < BEAT_W) begin : g_bad_width
            $error("reg_readout: DATA_W must be an integer multiple of BEAT_W");
        end
    endgenerate

    readout_state_t    state;
    logic [DATA_W-1:0] snap;
    logic [CNT_W-1:0]  cnt;
    logic              xfer;

    assign xfer     = out_valid && out_ready;
    assign out_last = out_valid && (cnt == LAST_CNT);

    // The snapshot is shifted toward the output end after each beat, so the
    // current beat always sits at a fixed slice.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign out_data = snap[BEAT_W-1:0];
        end else begin : g_msb
            assign out_data = snap[DATA_W-1 -: BEAT_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            snap      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        snap      <= reg_in;
                        cnt       <= '0;
                        state     <= SEND;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (cnt == LAST_CNT) begin
                            // Clearing the snapshot keeps out_data quiet in IDLE.
                            state     <= IDLE;
                            cnt       <= '0;
                            snap      <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            snap <= LSB_FIRST ? (snap >> BEAT_W) : (snap << BEAT_W);
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_readout.sv
module tb_reg_readout;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [63:0] reg_in;
    logic        out_ready;

    logic       busy_l, valid_l, last_l, done_l;
    logic [7:0] data_l;
    logic       busy_m, valid_m, last_m, done_m;
    logic [7:0] data_m;

    always #5 clk = ~clk;

    reg_readout #(.DATA_W(64), .BEAT_W(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset_n(reset_n), .req(req), .reg_in(reg_in),
        .busy(busy_l), .out_valid(valid_l), .out_ready(out_ready),
        .out_data(data_l), .out_last(last_l), .done(done_l)
    );

    reg_readout #(.DATA_W(64), .BEAT_W(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .req(req), .reg_in(reg_in),
        .busy(busy_m), .out_valid(valid_m), .out_ready(out_ready),
        .out_data(data_m), .out_last(last_m), .done(done_m)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a readback is just a list of pending beats for each ordering.
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    logic       exp_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_l.delete();
            q_m.delete();
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (q_l.size() > 0) begin
                if (out_ready) begin
                    void'(q_l.pop_front());
                    void'(q_m.pop_front());
                    if (q_l.size() == 0) exp_done = 1'b1;
                end
            end else if (req) begin
                for (int i = 0; i < 8; i++) begin
                    q_l.push_back(reg_in[8*i +: 8]);
                    q_m.push_back(reg_in[8*(7-i) +: 8]);
                end
            end
        end
    end

    // Transfer logs and event counters for the directed checks.
    logic [7:0] log_l[$];
    logic [7:0] log_m[$];
    logic [7:0] lastbits_l, lastbits_m;
    int         done_cnt, busy_cnt;

    always @(negedge clk) begin
        chk("valid_l", valid_l, q_l.size() > 0);
        chk("busy_l",  busy_l,  q_l.size() > 0);
        chk("done_l",  done_l,  exp_done);
        chk("valid_m", valid_m, q_m.size() > 0);
        chk("busy_m",  busy_m,  q_m.size() > 0);
        chk("done_m",  done_m,  exp_done);
        if (q_l.size() > 0) begin
            chk("data_l", data_l, q_l[0]);
            chk("last_l", last_l, q_l.size() == 1);
            chk("data_m", data_m, q_m[0]);
            chk("last_m", last_m, q_m.size() == 1);
        end
        if (done_l) done_cnt++;
        if (busy_l) busy_cnt++;
        if (reset_n && valid_l && out_ready) begin
            if (log_l.size() < 8) lastbits_l[log_l.size()] = last_l;
            log_l.push_back(data_l);
        end
        if (reset_n && valid_m && out_ready) begin
            if (log_m.size() < 8) lastbits_m[log_m.size()] = last_m;
            log_m.push_back(data_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] v);
        reg_in = v;
        req    = 1'b1;
        tick();
        req    = 1'b0;
    endtask

    task automatic clear_logs();
        log_l.delete();
        log_m.delete();
        lastbits_l = '0;
        lastbits_m = '0;
        done_cnt   = 0;
        busy_cnt   = 0;
    endtask

    // Returns the number of negedges (after the accepting edge) before done.
    task automatic wait_done(input int budget, output int k);
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_l) break;
        end
        chk("done_seen", k < budget, 1'b1);
    endtask

    task automatic chk_log(input string name, input logic [63:0] beats, input bit lsb_side);
        logic [7:0] b;
        if (lsb_side) chk({name, "_len"}, log_l.size(), 8);
        else          chk({name, "_len"}, log_m.size(), 8);
        for (int i = 0; i < 8; i++) begin
            b = beats[63 - 8*i -: 8];
            if (lsb_side && i < log_l.size()) chk(name, log_l[i], b);
            if (!lsb_side && i < log_m.size()) chk(name, log_m[i], b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n   = 1'b0;
        req       = 1'b0;
        reg_in    = '0;
        out_ready = 1'b1;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {valid_l, valid_m}, 2'b00);
        chk("rst_busy",  {busy_l, busy_m},   2'b00);
        chk("rst_data",  {data_l, data_m},   16'h0000);
        chk("rst_flags", {last_l, last_m, done_l, done_m}, 4'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic stream in both orderings.
        clear_logs();
        start(64'h0123_4567_89AB_CDEF);
        wait_done(20, k);
        chk("done_latency", k, 8);
        chk("busy_cycles", busy_cnt, 8);
        chk_log("beats_lsb", 64'hEFCD_AB89_6745_2301, 1'b1);
        chk_log("beats_msb", 64'h0123_4567_89AB_CDEF, 1'b0);
        chk("last_pos_l", lastbits_l, 8'h80);
        chk("last_pos_m", lastbits_m, 8'h80);
        tick();
        tick();

        // Backpressure with ready pattern 1,0,0,1.
        clear_logs();
        start(64'hFEDC_BA98_7654_3210);
        for (int j = 0; j < 40; j++) begin
            out_ready = (j % 4 == 0) || (j % 4 == 3);
            tick();
        end
        out_ready = 1'b1;
        chk_log("bp_lsb", 64'h1032_5476_98BA_DCFE, 1'b1);
        chk_log("bp_msb", 64'hFEDC_BA98_7654_3210, 1'b0);
        chk("bp_done_cnt", done_cnt, 1);

        // Snapshot isolation; req during SEND is ignored.
        clear_logs();
        start(64'h0123_4567_89AB_CDEF);
        tick();
        tick();
        tick();
        reg_in = 64'hFFFF_FFFF_FFFF_FFFF;
        req    = 1'b1;
        tick();
        req    = 1'b0;
        repeat (12) tick();
        chk_log("iso_lsb", 64'hEFCD_AB89_6745_2301, 1'b1);
        chk("iso_done_cnt", done_cnt, 1);
        chk("iso_busy_cycles", busy_cnt, 8);

        // Asynchronous reset mid-readback.
        clear_logs();
        start(64'h0123_4567_89AB_CDEF);
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {valid_l, valid_m}, 2'b00);
        chk("arst_busy",  {busy_l, busy_m},   2'b00);
        chk("arst_data",  {data_l, data_m},   16'h0000);
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        repeat (3) tick();
        chk("arst_no_done", done_cnt, 0);
        clear_logs();
        start(64'h0);
        repeat (10) tick();
        chk_log("zero_lsb", 64'h0, 1'b1);
        chk("zero_done_cnt", done_cnt, 1);

        // Back-to-back: new req in the done cycle.
        clear_logs();
        start(64'h1122_3344_5566_7788);
        wait_done(20, k);
        reg_in = 64'hA1B2_C3D4_E5F6_0718;
        req    = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        chk("b2b_valid", {valid_l, valid_m}, 2'b11);
        chk("b2b_first_l", data_l, 8'h18);
        chk("b2b_first_m", data_m, 8'hA1);
        #1;
        repeat (12) tick();
        chk("b2b_done_cnt", done_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_readout.md
Name: reg_readout

Overview:
- Read side of the 64-bit datapath register: on request, takes a snapshot of a register's output value.
- Streams the snapshot out as fixed-width beats over a valid/ready interface, for debug readback and narrow-bus transfer.
- Decouples the live register value from the slower consumer; the snapshot is immune to later register changes.

Parameters:
- DATA_W, 64, width of the register value being read.
- BEAT_W, 8, width of each output beat. DATA_W must be an integer multiple of BEAT_W; elaboration fails otherwise.
- LSB_FIRST, 1, 1 = least-significant beat sent first; 0 = most-significant beat first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  start a readback; sampled only in IDLE.
- reg_in  input  DATA_W  register value to snapshot.
- busy  output  1  high while a readback is in progress (SEND state).
- out_valid  output  1  beat available on out_data.
- out_ready  input  1  consumer accepts beat when high with out_valid.
- out_data  output  BEAT_W  current beat.
- out_last  output  1  high with out_valid on the final beat.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; snapshot = 0; beat counter = 0; busy, out_valid, out_last and done = 0; out_data = 0.
  - Reset mid-readback aborts the transfer: no done pulse, remaining beats discarded.
- NBEATS = DATA_W/BEAT_W. The beat counter is sized clog2(NBEATS), minimum 1 bit.
- State IDLE:
  - out_valid = 0, busy = 0.
  - req high at rising edge N: capture reg_in into the snapshot, counter = 0, go to SEND.
  - At cycle N+1, out_valid = 1 and beat 0 is on out_data.
- State SEND:
  - out_valid = 1, busy = 1.
  - out_data = snapshot[BEAT_W-1:0] when LSB_FIRST, else snapshot[DATA_W-1 -: BEAT_W].
  - out_last = 1 when counter == NBEATS-1.
- Handshake:
  - A beat transfers on a rising edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable. out_valid never drops before transfer.
- On transfer, not last: shift the snapshot by BEAT_W toward the output end (right when LSB_FIRST, left otherwise), zero-filling; counter++.
- On transfer of the last beat: go to IDLE; done = 1 for exactly the next cycle; counter = 0.
- req while in SEND, including the cycle of the final transfer, is ignored. Requests are not queued.
- req in the cycle that done is high is accepted, because the block is in IDLE.
- reg_in changes after capture have no effect on the beats of the current readback.
- Throughput with out_ready held high:
  - req at N → beats at N+1 … N+NBEATS, done at N+NBEATS+1.
  - With the defaults, 8 beats and done at N+9.
- Back-to-back: the earliest next req is accepted at N+NBEATS+1, giving first beat at N+NBEATS+2. One idle cycle between readbacks.

Decomposition:
- Shared package reg_pkg holds:
  - REG_W = 64, the datapath register width, used as the DATA_W default.
  - The typedef enum for readout state {IDLE, SEND}.
- No sub-module: the snapshot shifter and counter are small enough to stay inline. Target is about 120-160 lines.

Test Plan:
- Basic LSB-first (defaults): reg_in = 64'h0123_4567_89AB_CDEF, req pulse, out_ready = 1 → beats EF, CD, AB, 89, 67, 45, 23, 01 in consecutive cycles; out_last only on 01; done one cycle after; busy high for exactly 8 cycles.
- MSB-first (LSB_FIRST = 0): same value → beats 01, 23, 45, 67, 89, AB, CD, EF; out_last on EF.
- Backpressure: out_ready toggles 1,0,0,1,… → out_data and out_last stable during every stall; all 8 beats delivered exactly once, in order.
- Snapshot isolation and ignored req: change reg_in to 64'hFFFF_FFFF_FFFF_FFFF and pulse req mid-transfer → original value's beats unchanged; no second readback starts; single done pulse.
- Reset mid-operation: assert reset_n low after beat 3 (asynchronous, between edges) → out_valid, busy and out_data go to 0 immediately; no done pulse. After release, a new req with 64'h0 yields 8 zero beats.
- Back-to-back: req again in the done cycle → second readback's first beat appears the following cycle, with correct data.
